or1200_vlx_rd: RTL and testbench
================================

OR1200_VLX_RD -- requirements
Module: or1200_vlx_rd

Interface
REQ-001 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port get_bit_op_i  input  1  high while CPU executes a get-bits instruction.
REQ-004 SHALL have port num_bits_to_read_i  input  5  requested bit count n.
REQ-005 SHALL have port ack_i  input  1  memory acknowledge for the current byte load.
REQ-006 SHALL have port dat_i  input  32  load data; byte taken from dat_i[7:0].
REQ-007 SHALL have ports spr_cs, spr_write (input 1), spr_addr (input 2) and spr_dat_i (input 32) for SPR access.
REQ-008 SHALL have port spr_dat_o  output  32  SPR read data.
REQ-009 SHALL have port stall_cpu_o  output  1  stalls the CPU when high.
REQ-010 SHALL have port vlx_addr_o  output  32  byte address of the current load.
REQ-011 SHALL have port load_byte_o  output  1  byte load request, held until ack_i.
REQ-012 SHALL have port bits_o  output  32  right-justified result of the get-bits operation, upper bits zero.

Function
REQ-013 SHALL hold a 32-bit MSB-aligned bit buffer plus a 6-bit count (0..32) of valid bits.
REQ-014 SHALL write spr_dat_i to the address register when spr_cs & spr_write & spr_addr[1].
REQ-015 SHALL, on that SPR write, clear buffer, count, FF flag and marker flag, and enter FETCH.
REQ-016 SHALL return {marker_flag, 25'b0, count} on spr_dat_o for spr_addr[1]=0, and the address register for spr_addr[1]=1.
REQ-017 SHALL implement states IDLE (after reset), FETCH, DRAIN and HALT.
REQ-018 In FETCH, SHALL assert load_byte_o while count <= 24, with vlx_addr_o equal to the address register.
REQ-019 SHALL increment the address by 1 on every ack_i in FETCH, including for discarded stuffing bytes.
REQ-020 SHALL insert an accepted byte at buffer bits [31-count -: 8] and add 8 to count.
REQ-021 SHALL, for a fetched 0xFF, insert it and set the FF flag.
REQ-022 SHALL, for a byte following a 0xFF that equals 0x00, discard it, clear the FF flag and leave count unchanged.
REQ-023 SHALL, for a nonzero byte following a 0xFF, not insert it, set the marker flag and enter HALT.
REQ-024 In HALT, SHALL issue no loads and shall supply 1-bits as padding whenever a request exceeds count.
REQ-025 SHALL, on an SPR address write while load_byte_o is outstanding, enter DRAIN; DRAIN keeps load_byte_o high until ack_i, discards that data, then enters FETCH.
REQ-026 SHALL treat n=0 as a no-op: bits_o=0, no stall, no consume.
REQ-027 SHALL saturate n values 17..31 to 16.
REQ-028 SHALL drive stall_cpu_o combinationally high when get_bit_op_i is high and count < n, outside HALT.
REQ-029 SHALL, when get_bit_op_i is high and count >= n (or in HALT), drive bits_o from the top n bits in the same cycle, deassert stall_cpu_o, and consume at the next edge: buffer shifts left n, count -= n.
REQ-030 SHALL, on simultaneous consume and byte accept, place the byte at [31-(count-n) -: 8], giving count' = count - n + 8.
REQ-031 SHALL have zero-cycle latency when bits are available; otherwise it stalls until the refill edge and releases in the following cycle.
REQ-032 In IDLE, a get-bits SHALL return 0 without stall.

Reset
REQ-033 On rst_i, SHALL enter IDLE with buffer, count, address, FF and marker flags at 0, load_byte_o=0, stall_cpu_o=0, bits_o=0 and spr_dat_o=0, at the next edge, including mid-load; a pending ack_i after reset is ignored.

Verification
REQ-034 Scenario: set address 0x1000, memory bytes A5 3C, ack on the next cycle -> loads at 0x1000 and 0x1001; get 4 returns 0xA, get 8 returns 0x53.
REQ-035 Scenario: bytes FF 00 12 -> address advances by 3, count reaches 16; get 16 returns 0xFF12.
REQ-036 Scenario: bytes 7F FF D9 -> HALT with marker flag set; get 16 returns 0x7FFF, and the following get 8 returns 0xFF padding with no stall.
REQ-037 Scenario: get 12 issued with count=0 and ack delay of 3 cycles -> stall_cpu_o high until two bytes are accepted, then bits_o is valid with stall low.
REQ-038 Scenario: SPR address write during an outstanding load -> DRAIN; the acked byte is discarded; the next load goes to the new address.
REQ-039 Scenario: rst_i asserted while load_byte_o is high -> all outputs 0 after one edge; the late ack_i has no effect.

Source files
------------

// File: rtl/or1200_vlx_rd.sv
// Variable-length bit reader: fetches bytes from memory into an MSB-aligned bit
// buffer, removes JPEG-style 0xFF00 stuffing and stops at markers.
module or1200_vlx_rd (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        get_bit_op_i,
  input  logic [4:0]  num_bits_to_read_i,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  input  logic        spr_cs,
  input  logic        spr_write,
  input  logic [1:0]  spr_addr,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic        stall_cpu_o,
  output logic [31:0] vlx_addr_o,
  output logic        load_byte_o,
  output logic [31:0] bits_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t             state_p0;
  logic        [31:0] buf_p0;
  logic        [5:0]  cnt_p0;
  logic        [31:0] addr_p0;
  logic               ff_p0;
  logic               marker_p0;

  logic        [4:0]  n_eff;
  logic               req;
  logic               avail;
  logic               consume;
  logic               accept;
  logic               addr_wr;
  logic        [7:0]  byte_in;
  logic        [31:0] pad_mask;
  logic        [31:0] view;
  logic        [31:0] buf_after;
  logic        [5:0]  cnt_after;
  logic               unused_inputs;

  function automatic logic [4:0] sat_n(input logic [4:0] n);
    return (n > 5'd16) ? 5'd16 : n;
  endfunction

  assign unused_inputs = ^{spr_addr[0], dat_i[31:8]};

  assign n_eff       = sat_n(num_bits_to_read_i);
  assign byte_in     = dat_i[7:0];
  assign addr_wr     = spr_cs & spr_write & spr_addr[1];
  assign req         = get_bit_op_i && (n_eff != 5'd0) && (state_p0 != IDLE);
  assign avail       = (state_p0 == HALT) || ({1'b0, n_eff} <= cnt_p0);
  assign consume     = req && avail;
  assign stall_cpu_o = req && !avail;
  assign load_byte_o = ((state_p0 == FETCH) && (cnt_p0 <= 6'd24)) || (state_p0 == DRAIN);
  assign accept      = (state_p0 == FETCH) && load_byte_o && ack_i;
  assign vlx_addr_o  = addr_p0;
  assign spr_dat_o   = spr_addr[1] ? addr_p0 : {marker_p0, 25'b0, cnt_p0};

  // After a marker the stream is exhausted; bits past the valid ones read as 1.
  assign pad_mask = (state_p0 != HALT) ? 32'h0 :
                    (cnt_p0 >= 6'd32)  ? 32'h0 : (32'hFFFF_FFFF >> cnt_p0);
  assign view     = buf_p0 | pad_mask;
  assign bits_o   = consume ? (view >> (6'd32 - {1'b0, n_eff})) : 32'h0;

  always_comb begin
    buf_after = buf_p0;
    cnt_after = cnt_p0;
    if (consume) begin
      buf_after = buf_p0 << n_eff;
      cnt_after = ({1'b0, n_eff} > cnt_p0) ? 6'd0 : (cnt_p0 - {1'b0, n_eff});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0  <= IDLE;
      buf_p0    <= 32'h0;
      cnt_p0    <= 6'd0;
      addr_p0   <= 32'h0;
      ff_p0     <= 1'b0;
      marker_p0 <= 1'b0;
    end else if (addr_wr) begin
      addr_p0   <= spr_dat_i;
      buf_p0    <= 32'h0;
      cnt_p0    <= 6'd0;
      ff_p0     <= 1'b0;
      marker_p0 <= 1'b0;
      // A load still in flight must be retired before fetching from the new address.
      state_p0  <= (load_byte_o && !ack_i) ? DRAIN : FETCH;
    end else begin
      buf_p0 <= buf_after;
      cnt_p0 <= cnt_after;
      case (state_p0)
        FETCH: begin
          if (accept) begin
            addr_p0 <= addr_p0 + 32'd1;
            if (ff_p0) begin
              ff_p0 <= 1'b0;
              if (byte_in != 8'h00) begin
                marker_p0 <= 1'b1;
                state_p0  <= HALT;
              end
            end else begin
              buf_p0 <= buf_after | ({byte_in, 24'h0} >> cnt_after);
              cnt_p0 <= cnt_after + 6'd8;
              ff_p0  <= (byte_in == 8'hFF);
            end
          end
        end
        DRAIN: begin
          if (ack_i) state_p0 <= FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_vlx_rd.sv
// Directed bench for or1200_vlx_rd with a byte-memory responder of programmable ack delay.
module tb_or1200_vlx_rd;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        get_bit_op_i;
  logic [4:0]  num_bits_to_read_i;
  logic        ack_i;
  logic [31:0] dat_i;
  logic        spr_cs;
  logic        spr_write;
  logic [1:0]  spr_addr;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;
  logic        stall_cpu_o;
  logic [31:0] vlx_addr_o;
  logic        load_byte_o;
  logic [31:0] bits_o;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:7];
  int          mem_len = 0;
  logic [31:0] mem_base = 32'h0;
  int          ack_delay = 1;
  bit          resp_en = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_dat = 32'h0;

  or1200_vlx_rd dut (
    .clk_i(clk_i), .rst_i(rst_i), .get_bit_op_i(get_bit_op_i),
    .num_bits_to_read_i(num_bits_to_read_i), .ack_i(ack_i), .dat_i(dat_i),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr), .spr_dat_i(spr_dat_i),
    .spr_dat_o(spr_dat_o), .stall_cpu_o(stall_cpu_o), .vlx_addr_o(vlx_addr_o),
    .load_byte_o(load_byte_o), .bits_o(bits_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: acks ack_delay cycles after a request, one byte per ack.
  initial begin
    int          wcnt;
    logic [31:0] diff;
    wcnt  = 0;
    ack_i = 1'b0;
    dat_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!resp_en) begin
        ack_i = man_ack;
        dat_i = man_dat;
        wcnt  = 0;
      end else if (ack_i) begin
        ack_i = 1'b0;
        wcnt  = 0;
      end else if (load_byte_o) begin
        wcnt++;
        diff = vlx_addr_o - mem_base;
        if (wcnt >= ack_delay && diff < 32'(mem_len)) begin
          ack_i = 1'b1;
          dat_i = {24'h0, mem[diff[2:0]]};
          wcnt  = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_i = 1'b1;
    get_bit_op_i = 1'b0;
    num_bits_to_read_i = 5'd0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0; spr_dat_i = 32'h0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic spr_wr(input logic [31:0] a);
    @(negedge clk_i);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 2'd2; spr_dat_i = a;
    @(posedge clk_i); #1;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0;
  endtask

  task automatic spr_rd(input logic sel, output logic [31:0] d);
    spr_addr = {sel, 1'b0};
    #1 d = spr_dat_o;
    spr_addr = 2'd0;
  endtask

  task automatic do_get(input logic [4:0] n, output logic [31:0] b, output logic s);
    @(negedge clk_i);
    get_bit_op_i = 1'b1; num_bits_to_read_i = n;
    #1 b = bits_o; s = stall_cpu_o;
    @(posedge clk_i); #1;
    get_bit_op_i = 1'b0; num_bits_to_read_i = 5'd0;
  endtask

  task automatic load_mem(input logic [31:0] base, input int len,
                          input logic [63:0] bytes, input int dly);
    mem_base = base; mem_len = len; ack_delay = dly;
    for (int i = 0; i < 8; i++) mem[i] = bytes[63 - 8*i -: 8];
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    checks++; if (load_byte_o !== 1'b0) begin failures++; $display("FAIL rst_load got=%b exp=0", load_byte_o); end
    checks++; if (vlx_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", vlx_addr_o); end
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_spr0 got=%h exp=0", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_spr1 got=%h exp=0", d); end
    do_get(5'd5, b, s);
    checks++; if (b !== 32'h0 || s !== 1'b0) begin failures++; $display("FAIL idle_get bits=%h stall=%b exp bits=0 stall=0", b, s); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h1000, 2, 64'hA53C_0000_0000_0000, 1);
    spr_wr(32'h1000);
    checks++; if (load_byte_o !== 1'b1 || vlx_addr_o !== 32'h1000) begin failures++; $display("FAIL basic_load0 load=%b addr=%h exp 1/00001000", load_byte_o, vlx_addr_o); end
    @(posedge clk_i); #1;
    checks++; if (load_byte_o !== 1'b1 || vlx_addr_o !== 32'h1001) begin failures++; $display("FAIL basic_load1 load=%b addr=%h exp 1/00001001", load_byte_o, vlx_addr_o); end
    repeat (8) @(posedge clk_i); #1;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL basic_cnt got=%h exp=10", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h1002) begin failures++; $display("FAIL basic_addr got=%h exp=1002", d); end
    do_get(5'd4, b, s);
    checks++; if (b !== 32'hA || s !== 1'b0) begin failures++; $display("FAIL basic_get4 bits=%h stall=%b exp bits=a stall=0", b, s); end
    do_get(5'd8, b, s);
    checks++; if (b !== 32'h53 || s !== 1'b0) begin failures++; $display("FAIL basic_get8 bits=%h stall=%b exp bits=53 stall=0", b, s); end
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL basic_cnt_after got=%h exp=4", d); end
  endtask

  task automatic test_stuffing();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h2000, 3, 64'hFF00_1200_0000_0000, 1);
    spr_wr(32'h2000);
    repeat (10) @(posedge clk_i); #1;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL stuff_cnt got=%h exp=10", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h2003) begin failures++; $display("FAIL stuff_addr got=%h exp=2003", d); end
    do_get(5'd16, b, s);
    checks++; if (b !== 32'hFF12 || s !== 1'b0) begin failures++; $display("FAIL stuff_get16 bits=%h stall=%b exp bits=ff12 stall=0", b, s); end
  endtask

  task automatic test_marker();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h3000, 3, 64'h7FFF_D900_0000_0000, 1);
    spr_wr(32'h3000);
    repeat (10) @(posedge clk_i); #1;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h8000_0010) begin failures++; $display("FAIL marker_spr got=%h exp=80000010", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h3003) begin failures++; $display("FAIL marker_addr got=%h exp=3003", d); end
    checks++; if (load_byte_o !== 1'b0) begin failures++; $display("FAIL marker_load got=%b exp=0", load_byte_o); end
    do_get(5'd16, b, s);
    checks++; if (b !== 32'h7FFF || s !== 1'b0) begin failures++; $display("FAIL marker_get16 bits=%h stall=%b exp bits=7fff stall=0", b, s); end
    do_get(5'd8, b, s);
    checks++; if (b !== 32'hFF || s !== 1'b0) begin failures++; $display("FAIL marker_pad bits=%h stall=%b exp bits=ff stall=0", b, s); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int stall_cycles;
    bit released;
    do_reset();
    load_mem(32'h4000, 2, 64'hABCD_0000_0000_0000, 3);
    spr_wr(32'h4000);
    @(negedge clk_i);
    get_bit_op_i = 1'b1; num_bits_to_read_i = 5'd12;
    stall_cycles = 0;
    released = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!stall_cpu_o) begin released = 1'b1; break; end
      stall_cycles++;
      @(negedge clk_i);
    end
    checks++; if (!released) begin failures++; $display("FAIL stall_timeout stall=%b exp=0 within 30 cycles", stall_cpu_o); end
    checks++; if (stall_cycles != 7) begin failures++; $display("FAIL stall_cycles got=%0d exp=7", stall_cycles); end
    checks++; if (bits_o !== 32'hABC) begin failures++; $display("FAIL stall_bits got=%h exp=abc", bits_o); end
    @(posedge clk_i); #1;
    get_bit_op_i = 1'b0; num_bits_to_read_i = 5'd0;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL stall_cnt_after got=%h exp=4", d); end
  endtask

  task automatic test_drain();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h6000, 2, 64'h1122_0000_0000_0000, 4);
    spr_wr(32'h5000);
    checks++; if (load_byte_o !== 1'b1 || vlx_addr_o !== 32'h5000) begin failures++; $display("FAIL drain_load0 load=%b addr=%h exp 1/00005000", load_byte_o, vlx_addr_o); end
    spr_wr(32'h6000);
    checks++; if (load_byte_o !== 1'b1) begin failures++; $display("FAIL drain_hold got=%b exp=1", load_byte_o); end
    repeat (25) @(posedge clk_i); #1;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL drain_cnt got=%h exp=10", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h6002) begin failures++; $display("FAIL drain_addr got=%h exp=6002", d); end
    do_get(5'd16, b, s);
    checks++; if (b !== 32'h1122) begin failures++; $display("FAIL drain_get16 got=%h exp=1122", b); end
  endtask

  task automatic test_nsat();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h8000, 4, 64'h1234_5678_0000_0000, 1);
    spr_wr(32'h8000);
    repeat (12) @(posedge clk_i); #1;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h20 || load_byte_o !== 1'b0) begin failures++; $display("FAIL nsat_full cnt=%h load=%b exp cnt=20 load=0", d, load_byte_o); end
    do_get(5'd0, b, s);
    checks++; if (b !== 32'h0 || s !== 1'b0) begin failures++; $display("FAIL nsat_zero bits=%h stall=%b exp bits=0 stall=0", b, s); end
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h20) begin failures++; $display("FAIL nsat_zero_cnt got=%h exp=20", d); end
    do_get(5'd20, b, s);
    checks++; if (b !== 32'h1234) begin failures++; $display("FAIL nsat_get20 got=%h exp=1234", b); end
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL nsat_cnt got=%h exp=10", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] b;
    logic s;
    do_reset();
    load_mem(32'h9000, 3, 64'h8142_C300_0000_0000, 1);
    spr_wr(32'h9000);
    repeat (4) @(posedge clk_i);
    do_get(5'd4, b, s);
    checks++; if (b !== 32'h8 || s !== 1'b0) begin failures++; $display("FAIL b2b_get4 bits=%h stall=%b exp bits=8 stall=0", b, s); end
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h14) begin failures++; $display("FAIL b2b_cnt got=%h exp=14", d); end
    do_get(5'd16, b, s);
    checks++; if (b !== 32'h142C) begin failures++; $display("FAIL b2b_get16 got=%h exp=142c", b); end
    do_get(5'd4, b, s);
    checks++; if (b !== 32'h3) begin failures++; $display("FAIL b2b_get4b got=%h exp=3", b); end
  endtask

  task automatic test_reset_midload();
    logic [31:0] d;
    do_reset();
    resp_en = 1'b0; man_ack = 1'b0; man_dat = 32'h0;
    spr_wr(32'h7000);
    checks++; if (load_byte_o !== 1'b1) begin failures++; $display("FAIL rml_load got=%b exp=1", load_byte_o); end
    rst_i = 1'b1; man_ack = 1'b1; man_dat = 32'h99;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    get_bit_op_i = 1'b1; num_bits_to_read_i = 5'd8;
    #1;
    checks++; if (load_byte_o !== 1'b0 || stall_cpu_o !== 1'b0 || bits_o !== 32'h0) begin failures++; $display("FAIL rml_outs load=%b stall=%b bits=%h exp all 0", load_byte_o, stall_cpu_o, bits_o); end
    @(posedge clk_i); #1;
    get_bit_op_i = 1'b0; num_bits_to_read_i = 5'd0;
    spr_rd(1'b0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rml_cnt got=%h exp=0", d); end
    spr_rd(1'b1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rml_addr got=%h exp=0", d); end
    man_ack = 1'b0;
    @(posedge clk_i); #1;
    resp_en = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    get_bit_op_i = 1'b0; num_bits_to_read_i = 5'd0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'd0; spr_dat_i = 32'h0;
    test_reset();
    test_basic();
    test_stuffing();
    test_marker();
    test_stall();
    test_drain();
    test_nsat();
    test_back_to_back();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
